// File: rtl/tapped_shift_register.sv
// Tapped shift register: a STAGES-deep data/valid pipeline with a selectable
// output tap, the valid count up to that tap, and an optional output register.
module tapped_shift_register #(
  parameter int unsigned SIZE    = 32,
  parameter int unsigned STAGES  = 8,
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned OUT_REG = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             flush,
  input  logic [SIZE-1:0]  din,
  input  logic             din_valid,
  input  logic [SEL_W-1:0] depth_sel,
  output logic [SIZE-1:0]  dout,
  output logic             dout_valid,
  output logic [SEL_W:0]   occupancy
);

  localparam int unsigned OCC_W   = SEL_W + 1;
  localparam int unsigned MAX_TAP = STAGES - 1;

  logic [STAGES-1:0][SIZE-1:0] stage_q, stage_d;
  logic [STAGES-1:0]           v_q, v_d;

  logic [SEL_W-1:0] tap_c;
  logic [SIZE-1:0]  dout_c;
  logic             dout_valid_c;
  logic [OCC_W-1:0] occupancy_c;

  // Pipeline advance; flush wins over enable and drops din.
  always_comb begin
    stage_d = stage_q;
    v_d     = v_q;
    if (flush) begin
      stage_d = '0;
      v_d     = '0;
    end else if (enable) begin
      stage_d = {stage_q[STAGES-2:0], din};
      v_d     = {v_q[STAGES-2:0], din_valid};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_q <= '0;
      v_q     <= '0;
    end else begin
      stage_q <= stage_d;
      v_q     <= v_d;
    end
  end

  // Out-of-range selects collapse onto the last stage.
  always_comb begin
    tap_c = depth_sel;
    if (32'(depth_sel) > MAX_TAP) begin
      tap_c = SEL_W'(MAX_TAP);
    end
  end

  // Tap mux and valid count over stages 0..tap, driven only by registers.
  always_comb begin
    dout_c       = '0;
    dout_valid_c = 1'b0;
    occupancy_c  = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      if (SEL_W'(i) == tap_c) begin
        dout_c       = stage_q[i];
        dout_valid_c = v_q[i];
      end
      if (SEL_W'(i) <= tap_c) begin
        occupancy_c = occupancy_c + OCC_W'(v_q[i]);
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [SIZE-1:0]  dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic [OCC_W-1:0] occupancy_q, occupancy_d;

    // Output stage samples every clock; a flush edge also blanks it.
    always_comb begin
      dout_d       = dout_c;
      dout_valid_d = dout_valid_c;
      occupancy_d  = occupancy_c;
      if (flush) begin
        dout_d       = '0;
        dout_valid_d = 1'b0;
        occupancy_d  = '0;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        dout_q       <= '0;
        dout_valid_q <= 1'b0;
        occupancy_q  <= '0;
      end else begin
        dout_q       <= dout_d;
        dout_valid_q <= dout_valid_d;
        occupancy_q  <= occupancy_d;
      end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign occupancy  = occupancy_q;
  end else begin : g_out_comb
    assign dout       = dout_c;
    assign dout_valid = dout_valid_c;
    assign occupancy  = occupancy_c;
  end

endmodule

// File: doc/tapped_shift_register.md
TAPPED_SHIFT_REGISTER -- requirements
Module: tapped_shift_register

Interface
REQ-001 The block SHALL have parameter SIZE, default 32, data width in bits.
REQ-002 The block SHALL have parameter STAGES, default 8, number of pipeline stages; legal range 2..256.
REQ-003 The block SHALL have parameter SEL_W, default 3, tap-select width; 2^SEL_W >= STAGES required.
REQ-004 The block SHALL have parameter OUT_REG, default 0; 1 adds an output register stage.
REQ-005 The block SHALL have port clk, input, 1, single clock; all state updates on posedge clk.
REQ-006 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port enable, input, 1, advance pipeline one stage when high.
REQ-008 The block SHALL have port flush, input, 1, synchronous invalidate of all stages.
REQ-009 The block SHALL have port din, input, SIZE, data entering stage 0.
REQ-010 The block SHALL have port din_valid, input, 1, valid tag travelling with din.
REQ-011 The block SHALL have port depth_sel, input, SEL_W, output tap index.
REQ-012 The block SHALL have port dout, output, SIZE, data at the selected tap.
REQ-013 The block SHALL have port dout_valid, output, 1, valid tag at the selected tap.
REQ-014 The block SHALL have port occupancy, output, SEL_W+1, count of valid stages 0..tap inclusive.

Function
REQ-015 The block SHALL hold STAGES data registers stage[0..STAGES-1] and STAGES valid bits v[0..STAGES-1].
REQ-016 Enable=1, flush=0: stage[0]<=din, v[0]<=din_valid, stage[i]<=stage[i-1], v[i]<=v[i-1] for i>=1, all in one clock.
REQ-017 Enable=0, flush=0: all stage and valid registers SHALL hold.
REQ-018 Flush=1: all v[i] and stage[i] SHALL clear to 0 on that edge; flush dominates enable; din is not captured.
REQ-019 Effective tap t SHALL be depth_sel, clamped to STAGES-1 when depth_sel >= STAGES.
REQ-020 OUT_REG=0: dout=stage[t], dout_valid=v[t], occupancy=popcount(v[0..t]), all combinational from registers and depth_sel.
REQ-021 OUT_REG=1: dout, dout_valid, occupancy SHALL be registered copies of the REQ-020 values, updated every clock regardless of enable.
REQ-022 OUT_REG=1 with flush=1: dout, dout_valid, occupancy SHALL be 0 on the cycle following the flush edge.
REQ-023 Latency: a word accepted at enable edge k appears on dout after t further enable edges (t+1 total); OUT_REG=1 adds one clock.
REQ-024 Word at stage STAGES-1 SHALL be discarded on the next enable edge; no overflow indication.
REQ-025 depth_sel change SHALL take effect immediately (OUT_REG=0) or next clock (OUT_REG=1); pipeline contents unaffected.
REQ-026 occupancy SHALL range 0..t+1 and never wrap.
REQ-027 No combinational path SHALL exist from din or din_valid to any output.

Reset
REQ-028 reset_n low SHALL immediately clear all stage, valid and output registers to 0, independent of clk.
REQ-029 During reset, dout=0, dout_valid=0, occupancy=0.
REQ-030 First enable edge after reset_n rises SHALL behave per REQ-016; reset mid-stream discards all in-flight words.

Verification
REQ-031 STAGES=8, OUT_REG=0, depth_sel=3, enable=1, din=0xA0..0xA7 valid each cycle -> dout=0xA0, dout_valid=1 after 4th edge; occupancy=4.
REQ-032 Same setup, enable low 2 cycles mid-stream -> dout and occupancy frozen 2 cycles, sequence resumes with no loss or duplication.
REQ-033 Pipeline full of valid words, flush=1 with enable=1 -> next cycle dout_valid=0, occupancy=0, din of flush cycle absent later.
REQ-034 depth_sel=9 with STAGES=8 -> behaves as tap 7; word 0x55 appears after 8 enable edges.
REQ-035 OUT_REG=1, depth_sel=0, din=0x12 valid at one edge -> dout=0x12, dout_valid=1 one clock later than OUT_REG=0 case.
REQ-036 reset_n asserted between edges with 5 valid words in flight -> outputs 0 immediately; after release, no stale word ever emerges.
